// File: rtl/ula_md_if.sv
// Request/result bundle between the MIPS datapath and the multiply/divide unit.
// The divzero signal exists only when ULA_MD_DIVZERO_EN is defined.
interface ula_md_if #(
   parameter int N = 32
);
   logic         start;
   logic [1:0]   ULAcontrole;
   logic [N-1:0] SrcA;
   logic [N-1:0] SrcB;
   logic         busy;
   logic         pronto;
   logic [N-1:0] hi;
   logic [N-1:0] lo;
`ifdef ULA_MD_DIVZERO_EN
   logic         divzero;
`endif

   modport master (
      output start, ULAcontrole, SrcA, SrcB,
      input  busy, pronto, hi, lo
`ifdef ULA_MD_DIVZERO_EN
      , input divzero
`endif
   );

   modport slave (
      input  start, ULAcontrole, SrcA, SrcB,
      output busy, pronto, hi, lo
`ifdef ULA_MD_DIVZERO_EN
      , output divzero
`endif
   );
endinterface

// File: rtl/ula_md.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per clock, results in HI/LO.
// Optional divide-by-zero flag output under ULA_MD_DIVZERO_EN.
module ula_md #(
   parameter int N = 32
) (
   input logic    clk,
   input logic    reset,
   ula_md_if.slave bus
);
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;

   state_t           r_state, w_next;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_op;
   logic [N-1:0]     r_a, r_b;
   logic [2*N-1:0]   r_p;
   logic             r_neg_lo, r_neg_hi;
   logic [N-1:0]     r_hi, r_lo;
   logic             r_pronto;

   logic             w_sa, w_sb;
   logic [N-1:0]     w_ma, w_mb;
   logic [N:0]       w_sum, w_rsh, w_diff;
   logic [2*N-1:0]   w_mul_nx, w_div_nx, w_prod;
   logic [N-1:0]     w_quo, w_rem;
   logic             w_dz;

   // Control FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = CALC;
         CALC:    if (r_cnt == CW'(N - 1)) w_next = FIM;
         FIM:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Signed ops work on magnitudes; sign fix-up happens in FIM
   assign w_sa = bus.ULAcontrole[0] & bus.SrcA[N-1];
   assign w_sb = bus.ULAcontrole[0] & bus.SrcB[N-1];
   assign w_ma = w_sa ? -bus.SrcA : bus.SrcA;
   assign w_mb = w_sb ? -bus.SrcB : bus.SrcB;

   // Shift-add step: r_p = {partial product, remaining multiplier bits}
   assign w_sum    = {1'b0, r_p[2*N-1:N]} + (r_p[0] ? {1'b0, r_a} : '0);
   assign w_mul_nx = {w_sum, r_p[N-1:1]};

   // Restoring step: r_p = {remainder, dividend bits shifting into quotient}
   assign w_rsh    = {r_p[2*N-1:N], r_p[N-1]};
   assign w_diff   = w_rsh - {1'b0, r_b};
   assign w_div_nx = {(w_diff[N] ? w_rsh[N-1:0] : w_diff[N-1:0]), r_p[N-2:0], ~w_diff[N]};

   assign w_prod = r_neg_lo ? -r_p : r_p;
   assign w_quo  = r_neg_lo ? -r_p[N-1:0] : r_p[N-1:0];
   assign w_rem  = r_neg_hi ? -r_p[2*N-1:N] : r_p[2*N-1:N];
   assign w_dz   = r_op[1] & (r_b == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_p      <= '0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (bus.start) begin
               r_cnt    <= '0;
               r_op     <= bus.ULAcontrole;
               r_a      <= w_ma;
               r_b      <= w_mb;
               r_p      <= {{N{1'b0}}, (bus.ULAcontrole[1] ? w_ma : w_mb)};
               r_neg_lo <= w_sa ^ w_sb;
               r_neg_hi <= w_sa;
            end
            CALC: begin
               r_cnt <= r_cnt + CW'(1);
               r_p   <= r_op[1] ? w_div_nx : w_mul_nx;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hi     <= '0;
         r_lo     <= '0;
         r_pronto <= 1'b0;
      end else begin
         r_pronto <= (r_state == FIM);
         if (r_state == FIM) begin
            if (r_op[1]) begin
               // Zero divisor: remainder path already reproduces the dividend
               r_hi <= w_rem;
               r_lo <= w_dz ? '1 : w_quo;
            end else begin
               r_hi <= w_prod[2*N-1:N];
               r_lo <= w_prod[N-1:0];
            end
         end
      end
   end

`ifdef ULA_MD_DIVZERO_EN
   logic r_divzero;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 r_divzero <= 1'b0;
      else if (r_state == FIM)   r_divzero <= w_dz;
   end
   assign bus.divzero = r_divzero;
`endif

   assign bus.busy   = (r_state == CALC);
   assign bus.pronto = r_pronto;
   assign bus.hi     = r_hi;
   assign bus.lo     = r_lo;
endmodule

// File: tb/tb_ula_md.sv
// Directed bench for ula_md (N=32): latency, MULT/DIV results, div-by-zero,
// back-to-back launch, ignored start and mid-operation reset.
module tb_ula_md;
   localparam int N = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tot = 0;
   int   n_bad = 0;

   ula_md_if #(.N(N)) bus ();
   ula_md #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Drive start for one edge; returns #1 after that edge
   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.ULAcontrole = op;
      bus.SrcA = a;
      bus.SrcB = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Counts edges until pronto is seen (bounded) and busy cycles on the way
   task automatic wait_pronto(output int cyc, output int nbusy);
      cyc = 0;
      nbusy = int'(bus.busy);
      do begin
         @(posedge clk); #1;
         cyc++;
         if (bus.busy) nbusy++;
      end while (!bus.pronto && cyc < 100);
   endtask

   task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
      int cyc, nb;
      launch(op, a, b);
      wait_pronto(cyc, nb);
      chk({tag, "_lat"}, 64'(cyc), 64'd33);
      chk({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
      chk({tag, "_lo"}, 64'(bus.lo), 64'(elo));
   endtask

   initial begin
      int cyc, nb, extra;
      bus.start = 1'b0;
      bus.ULAcontrole = 2'b00;
      bus.SrcA = '0;
      bus.SrcB = '0;
      #12 reset = 1'b0;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_pronto", 64'(bus.pronto), 64'd0);
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
`ifdef ULA_MD_DIVZERO_EN
      chk("rst_dz", 64'(bus.divzero), 64'd0);
`endif
      @(posedge clk); #1;

      // MULTU max*max, with busy-length check
      launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_pronto(cyc, nb);
      chk("multu_lat", 64'(cyc), 64'd33);
      chk("multu_busy", 64'(nb), 64'd32);
      chk("multu_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
      chk("multu_lo", 64'(bus.lo), 64'h0000_0000_0000_0001);
      @(posedge clk); #1;
      chk("pronto_pulse", 64'(bus.pronto), 64'd0);

      do_op("mult", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      do_op("div", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      do_op("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
      // launched in the pronto cycle of the previous op
      do_op("divu0", 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
`ifdef ULA_MD_DIVZERO_EN
      chk("dz_set", 64'(bus.divzero), 64'd1);
`endif
      do_op("div_min", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
`ifdef ULA_MD_DIVZERO_EN
      chk("dz_clr", 64'(bus.divzero), 64'd0);
`endif
      do_op("mult_neg", 2'b01, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'd0, 32'd42);

      // Second start during CALC must be ignored
      launch(2'b00, 32'd6, 32'd7);
      repeat (9) begin @(posedge clk); #1; end
      chk("hold_hi", 64'(bus.hi), 64'd0);
      chk("hold_lo", 64'(bus.lo), 64'd42);
      launch(2'b01, 32'd5, 32'd5);
      wait_pronto(cyc, nb);
      chk("ign_lat", 64'(cyc), 64'd23);
      chk("ign_hi", 64'(bus.hi), 64'd0);
      chk("ign_lo", 64'(bus.lo), 64'd42);
      extra = 0;
      repeat (40) begin @(posedge clk); #1; if (bus.pronto) extra++; end
      chk("ign_pronto", 64'(extra), 64'd0);

      // Reset mid-operation
      launch(2'b10, 32'd100, 32'd7);
      repeat (14) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      chk("mrst_busy", 64'(bus.busy), 64'd0);
      chk("mrst_pronto", 64'(bus.pronto), 64'd0);
      chk("mrst_hi", 64'(bus.hi), 64'd0);
      chk("mrst_lo", 64'(bus.lo), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      extra = 0;
      repeat (40) begin @(posedge clk); #1; if (bus.pronto) extra++; end
      chk("mrst_nopronto", 64'(extra), 64'd0);
      do_op("post_rst", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule

// File: doc/ula_md.md
Name: ula_md

Overview:
- Parametrised multi-cycle multiply/divide unit for the MIPS datapath; companion to the combinational ALU.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per clock.
- Holds results in HI/LO registers, which the datapath reads for MFHI/MFLO.
- Control FSM uses a start/busy/pronto handshake to stall the pipeline while an operation runs.

Parameters:
- N, 32, operand width in bits (N >= 4). HI and LO are each N bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  launch request; sampled only in IDLE.
- ULAcontrole  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- SrcA  input  N  multiplicand or dividend; sampled with start.
- SrcB  input  N  multiplier or divisor; sampled with start.
- busy  output  1  high while an operation is in progress.
- pronto  output  1  one-cycle pulse when HI/LO have just been updated.
- hi  output  N  HI register: upper product half, or remainder.
- lo  output  N  LO register: lower product half, or quotient.

Behaviour:
- Reset (asynchronous, takes effect immediately): FSM goes to IDLE; busy=0, pronto=0, hi=0, lo=0; all internal iteration registers cleared.
- Reset asserted mid-operation aborts the operation; no partial result reaches hi/lo.
- FSM states: IDLE, CALC, FIM.
  - IDLE & start=1: latch operands and opcode; go to CALC; counter=0; busy=1 from the next cycle.
  - IDLE & start=0: stay in IDLE; hi and lo hold.
  - CALC: one iteration per clock; counter increments; after N iterations go to FIM.
  - FIM: write hi/lo; pronto=1 for exactly this cycle; busy=0; next state IDLE.
  - start in CALC or FIM is ignored and not queued.
- Latency: start sampled at edge 0 -> CALC for edges 1..N -> new hi/lo visible and pronto=1 after edge N+1. Total N+1 cycles from start to result.
- Back-to-back: start may be asserted in the cycle pronto=1 is visible, i.e. the FSM is in IDLE after edge N+1. The next operation launches at edge N+2.
- Signed operations (MULT, DIV):
  - Operands are converted to magnitudes at latch time; result signs are fixed up in FIM.
  - MULT result is the full 2N-bit two's-complement product: hi = upper N bits, lo = lower N bits.
  - DIV quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIV of MIN / -1: lo=MIN, hi=0. No trap or flag.
- Unsigned operations (MULTU, DIVU): plain shift-add multiply and restoring divide on the raw operands.
- Divide by zero (SrcB=0 on DIV or DIVU): runs the full N+1-cycle latency; result hi=SrcA (unmodified), lo={N{1}}.
- hi/lo change only in FIM or on reset; they are stable during CALC.

Optional Feature:
- Macro ULA_MD_DIVZERO_EN.
- When defined:
  - Adds output port divzero (1 bit), reset value 0.
  - divzero is set in FIM of a DIV/DIVU whose latched divisor was 0.
  - It is cleared in FIM of any other operation and holds between operations.
- When undefined: the port is absent; divide-by-zero results are unchanged (hi=SrcA, lo={N{1}}).

Test Plan:
- N=32, MULTU, SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> pronto visible 33 cycles after start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high for 32 cycles.
- MULT, SrcA=-3 (0xFFFFFFFD), SrcB=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV, SrcA=-7, SrcB=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU 100/7 -> lo=14, hi=2. Issue DIVU 0x12345678/0 back-to-back, starting in the pronto cycle -> hi=0x12345678, lo=0xFFFFFFFF; with ULA_MD_DIVZERO_EN, divzero=1.
- DIV, SrcA=0x80000000, SrcB=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULTU 6*7; pulse start with other operands at cycle 10 -> second request ignored; hi=0, lo=42; no second pronto.
- Start DIVU 100/7, assert reset at cycle 15 -> busy, pronto, hi and lo all 0 immediately. After release, MULTU 2*3 -> lo=6 with normal N+1 latency.
